alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, handshaked arithmetic/logic unit that replaces the decoder-selected 4-bit ALU slice with a registered, WIDTH-generic datapath. It accepts one operation per valid/ready transfer: add, subtract, unsigned compare, AND, OR, XOR, or an iterative shift-add multiply. It returns the result, a high half and flags through a single output register with backpressure. It sits between the operand/opcode source (register file or test driver) and the result consumer in the ALU top level.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 4..32.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand/opcode present.
- in_ready  out  1  block can accept this cycle.
- op  in  3  000 ADD, 001 SUB, 010 CMP, 011 AND, 100 OR, 101 XOR, 110 MUL, 111 illegal.
- a, b  in  WIDTH  unsigned operands.
- out_valid  out  1  result register holds an undelivered result.
- out_ready  in  1  consumer accepts the result this cycle.
- y  out  WIDTH  result, low half for MUL.
- y_hi  out  WIDTH  MUL high half; 0 for all other ops.
- carry  out  1  ADD carry-out; SUB no-borrow (1 when a >= b); 0 otherwise.
- zero  out  1  y == 0 (and y_hi == 0 for MUL).
- err  out  1  op was 111.
- busy  out  1  multiply in progress.

## Operation
- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready at a rising edge.
- in_ready = (state == IDLE) && (!out_valid || out_ready). It is combinational from state, out_valid and out_ready, never from in_valid.
- FSM states:
  - IDLE: on accept of a non-MUL op, load y/y_hi/flags, set out_valid, stay in IDLE. On accept of MUL, latch a and b, clear the product accumulator and count, go to MUL.
  - MUL: one shift-add step per cycle, count 0..WIDTH-1. In the cycle where count == WIDTH-1, load the {y_hi, y} product, set out_valid and return to IDLE.
- ADD: {carry, y} = a + b, computed WIDTH+1 bits wide.
- SUB: {carry, y} = a + ~b + 1; y wraps modulo 2^WIDTH.
- CMP: y[0] = a > b, y[1] = a == b, y[2] = a < b; all other bits 0; carry 0.
- AND/OR/XOR: bitwise; carry 0.
- MUL: full 2*WIDTH-bit unsigned product; carry 0.
- Illegal (111): y = 0, y_hi = 0, err = 1, zero = 1; uses the single-cycle path.
- err is 0 for every legal op.
- Output register (y, y_hi, carry, zero, err) holds stable while out_valid && !out_ready.
- out_valid clears on an output transfer unless a new result loads on the same edge, in which case it stays 1 with the new data.
- Operands are latched at accept for MUL; changes on a/b/op during MUL have no effect.
- busy = (state == MUL).

## Timing
- Reset (asynchronous assert, synchronous-safe release): state = IDLE, out_valid = 0, y = y_hi = 0, carry = zero = err = 0, busy = 0, count = 0. in_ready reads 1 during and after reset.
- Reset asserted mid-MUL aborts the multiply immediately with no output. The first accept is possible on the first edge after release.
- Single-cycle ops: accept at edge k, result visible with out_valid = 1 after edge k.
- Throughput is one op per cycle while out_ready = 1.
- MUL: accept at edge k; steps occur at edges k+1..k+WIDTH; out_valid = 1 after edge k+WIDTH.
- in_ready = 0 from after edge k through edge k+WIDTH. Back-to-back MUL throughput is one per WIDTH+1 cycles.
- Simultaneous output drain and new accept on the same edge: legal, no bubble.
- Backpressure: with out_valid = 1 and out_ready = 0, in_ready = 0. No op is accepted or lost, and outputs are unchanged.

## Test plan
- WIDTH=8, ADD a=0xFF b=0x01, out_ready=1 -> one cycle later y=0x00, carry=1, zero=1, err=0.
- SUB a=0x05 b=0x07 -> y=0xFE, carry=0. Then SUB a=0x07 b=0x05 -> y=0x02, carry=1. Issued back-to-back on consecutive cycles, with results on consecutive cycles.
- CMP a=0x30 b=0x30 -> y=0x02. CMP a=0x10 b=0x30 -> y=0x04. op=111 -> y=0, err=1.
- MUL a=0xFF b=0xFF -> in_ready=0 and busy=1 for 8 cycles. out_valid rises 8 cycles after accept with y_hi=0xFE, y=0x01. Operands changed mid-multiply do not affect the result.
- Backpressure: hold out_ready=0 with XOR a=0xF0 b=0x3C pending (y=0xCC) and in_valid=1 with ADD -> in_ready=0 and y stays 0xCC. Raise out_ready for one cycle -> XOR result drains and the ADD is accepted on the same edge.
- Pulse rst_n low for 1 cycle at step 4 of MUL 0x12*0x34 -> all outputs 0 immediately and in_ready=1. A new MUL 0x12*0x34 after release yields y_hi=0x03, y=0xA8.

Source files
------------

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: handshake and result bundle for the pipelined ALU.
//   master modport: operand/opcode source and result consumer
//                   (drives in_valid, op, a, b, out_ready).
//   slave  modport: the ALU itself
//                   (drives in_ready, out_valid, y, y_hi, carry, zero, err, busy).
interface alu_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_hi;
  logic             carry;
  logic             zero;
  logic             err;
  logic             busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, y, y_hi, carry, zero, err, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, y, y_hi, carry, zero, err, busy
  );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked, WIDTH-generic ALU with a single registered result stage.
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - alu_pipe_if.slave: in_valid/in_ready/op/a/b on the input side,
//            out_valid/out_ready/y/y_hi/carry/zero/err plus busy on the output side.
// Single-cycle ops (ADD, SUB, CMP, AND, OR, XOR, illegal) load the result
// register on the accept edge. MUL runs a WIDTH-step shift-add sequence and
// loads the full product on the last step.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_pipe_if.slave   bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_CMP = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t             state_r;
  logic [CW-1:0]      count_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [2*WIDTH-1:0] acc_r;

  logic               out_valid_r;
  logic [WIDTH-1:0]   y_r;
  logic [WIDTH-1:0]   y_hi_r;
  logic               carry_r;
  logic               zero_r;
  logic               err_r;

  logic               in_ready_s;
  logic               accept_s;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH:0]     diff_s;
  logic [WIDTH-1:0]   res_y_s;
  logic               res_carry_s;
  logic               res_err_s;
  logic [2*WIDTH-1:0] step_add_s;
  logic [2*WIDTH-1:0] prod_next_s;
  logic               last_step_s;

  // Accept only from IDLE, and only when the result register is free or draining now.
  assign in_ready_s = (state_r == ST_IDLE) && (!out_valid_r || bus.out_ready);
  assign accept_s   = bus.in_valid && in_ready_s;

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.y         = y_r;
  assign bus.y_hi      = y_hi_r;
  assign bus.carry     = carry_r;
  assign bus.zero      = zero_r;
  assign bus.err       = err_r;
  assign bus.busy      = (state_r == ST_MUL);

  // Single-cycle datapath; SUB carry is the no-borrow bit of a + ~b + 1.
  always_comb begin
    sum_s       = {1'b0, bus.a} + {1'b0, bus.b};
    diff_s      = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
    res_y_s     = {WIDTH{1'b0}};
    res_carry_s = 1'b0;
    res_err_s   = 1'b0;
    case (bus.op)
      OP_ADD: begin
        res_y_s     = sum_s[WIDTH-1:0];
        res_carry_s = sum_s[WIDTH];
      end
      OP_SUB: begin
        res_y_s     = diff_s[WIDTH-1:0];
        res_carry_s = diff_s[WIDTH];
      end
      OP_CMP: begin
        res_y_s[0] = (bus.a > bus.b);
        res_y_s[1] = (bus.a == bus.b);
        res_y_s[2] = (bus.a < bus.b);
      end
      OP_AND: res_y_s = bus.a & bus.b;
      OP_OR:  res_y_s = bus.a | bus.b;
      OP_XOR: res_y_s = bus.a ^ bus.b;
      OP_MUL: res_y_s = {WIDTH{1'b0}};
      default: begin
        res_y_s   = {WIDTH{1'b0}};
        res_err_s = 1'b1;
      end
    endcase
  end

  // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    if (mplier_r[0]) begin
      step_add_s = mcand_r;
    end else begin
      step_add_s = {(2*WIDTH){1'b0}};
    end
    prod_next_s = acc_r + step_add_s;
    last_step_s = (count_r == CW'(WIDTH - 1));
  end

  // Control FSM, multiply sequencer and registered result stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      count_r     <= {CW{1'b0}};
      mcand_r     <= {(2*WIDTH){1'b0}};
      mplier_r    <= {WIDTH{1'b0}};
      acc_r       <= {(2*WIDTH){1'b0}};
      out_valid_r <= 1'b0;
      y_r         <= {WIDTH{1'b0}};
      y_hi_r      <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      zero_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s && (bus.op == OP_MUL)) begin
            // Operands are captured here so later changes on a/b/op are ignored.
            mcand_r     <= {{WIDTH{1'b0}}, bus.a};
            mplier_r    <= bus.b;
            acc_r       <= {(2*WIDTH){1'b0}};
            count_r     <= {CW{1'b0}};
            state_r     <= ST_MUL;
            out_valid_r <= 1'b0;
          end else if (accept_s) begin
            y_r         <= res_y_s;
            y_hi_r      <= {WIDTH{1'b0}};
            carry_r     <= res_carry_s;
            zero_r      <= (res_y_s == {WIDTH{1'b0}});
            err_r       <= res_err_s;
            out_valid_r <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
          end else begin
            out_valid_r <= out_valid_r;
          end
        end
        ST_MUL: begin
          acc_r    <= prod_next_s;
          mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
          if (last_step_s) begin
            {y_hi_r, y_r} <= prod_next_s;
            carry_r       <= 1'b0;
            zero_r        <= (prod_next_s == {(2*WIDTH){1'b0}});
            err_r         <= 1'b0;
            out_valid_r   <= 1'b1;
            count_r       <= {CW{1'b0}};
            state_r       <= ST_IDLE;
          end else begin
            count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
            // The accept edge already freed the result register; keep draining semantics anyway.
            if (bus.out_ready) begin
              out_valid_r <= 1'b0;
            end else begin
              out_valid_r <= out_valid_r;
            end
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          count_r     <= {CW{1'b0}};
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed self-checking bench for alu_pipe at WIDTH=8.
// Inputs are driven 1 time unit after a rising edge; outputs are sampled at the
// same point, i.e. after the edge has settled and before the next one.
module tb_alu_pipe;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  alu_pipe_if #(.WIDTH(8)) bus ();

  alu_pipe #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 3'b000;
    bus.a         = 8'h00;
    bus.b         = 8'h00;
    bus.out_ready = 1'b1;
    #2;
    tests_run++;
    if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    tests_run++;
    if ({bus.out_valid, bus.busy, bus.carry, bus.zero, bus.err} !== 5'b00000) begin
      tests_failed++; $display("FAIL reset_flags got %b want 00000", {bus.out_valid, bus.busy, bus.carry, bus.zero, bus.err});
    end
    tests_run++;
    if ({bus.y_hi, bus.y} !== 16'h0000) begin tests_failed++; $display("FAIL reset_y got %h want 0000", {bus.y_hi, bus.y}); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    bus.in_valid = 1'b1; bus.op = 3'b000; bus.a = 8'hFF; bus.b = 8'h01;
    tests_run++;
    if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL add_in_ready got %b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    tests_run++;
    if ({bus.out_valid, bus.y, bus.y_hi} !== 17'h1_00_00) begin
      tests_failed++; $display("FAIL add_y got v=%b y=%h hi=%h want v=1 y=00 hi=00", bus.out_valid, bus.y, bus.y_hi);
    end
    tests_run++;
    if ({bus.carry, bus.zero, bus.err} !== 3'b110) begin
      tests_failed++; $display("FAIL add_flags got %b want 110", {bus.carry, bus.zero, bus.err});
    end
    tick();
    tests_run++;
    if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL add_drain got %b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    bus.in_valid = 1'b1; bus.op = 3'b001; bus.a = 8'h05; bus.b = 8'h07;
    tick();
    tests_run++;
    if ({bus.out_valid, bus.y, bus.carry, bus.zero} !== {1'b1, 8'hFE, 1'b0, 1'b0}) begin
      tests_failed++; $display("FAIL sub1 got v=%b y=%h c=%b z=%b want v=1 y=fe c=0 z=0", bus.out_valid, bus.y, bus.carry, bus.zero);
    end
    bus.op = 3'b001; bus.a = 8'h07; bus.b = 8'h05;
    tests_run++;
    if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL sub2_in_ready got %b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    tests_run++;
    if ({bus.out_valid, bus.y, bus.carry, bus.err} !== {1'b1, 8'h02, 1'b1, 1'b0}) begin
      tests_failed++; $display("FAIL sub2 got v=%b y=%h c=%b e=%b want v=1 y=02 c=1 e=0", bus.out_valid, bus.y, bus.carry, bus.err);
    end
    tick();
  endtask

  task automatic test_logic_cmp();
    logic [2:0] ops [0:6];
    logic [7:0] as  [0:6];
    logic [7:0] bs  [0:6];
    logic [7:0] exp_y   [0:6];
    logic       exp_err [0:6];
    ops[0] = 3'b010; as[0] = 8'h30; bs[0] = 8'h30; exp_y[0] = 8'h02; exp_err[0] = 1'b0;
    ops[1] = 3'b010; as[1] = 8'h10; bs[1] = 8'h30; exp_y[1] = 8'h04; exp_err[1] = 1'b0;
    ops[2] = 3'b010; as[2] = 8'h31; bs[2] = 8'h30; exp_y[2] = 8'h01; exp_err[2] = 1'b0;
    ops[3] = 3'b011; as[3] = 8'hF0; bs[3] = 8'h3C; exp_y[3] = 8'h30; exp_err[3] = 1'b0;
    ops[4] = 3'b100; as[4] = 8'hF0; bs[4] = 8'h3C; exp_y[4] = 8'hFC; exp_err[4] = 1'b0;
    ops[5] = 3'b101; as[5] = 8'hA5; bs[5] = 8'hA5; exp_y[5] = 8'h00; exp_err[5] = 1'b0;
    ops[6] = 3'b111; as[6] = 8'h12; bs[6] = 8'h34; exp_y[6] = 8'h00; exp_err[6] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = 1'b1; bus.op = ops[i]; bus.a = as[i]; bus.b = bs[i];
      tick();
      tests_run++;
      if ({bus.out_valid, bus.y, bus.y_hi, bus.carry, bus.zero, bus.err} !==
          {1'b1, exp_y[i], 8'h00, 1'b0, (exp_y[i] == 8'h00), exp_err[i]}) begin
        tests_failed++;
        $display("FAIL op%0d_vec%0d got v=%b y=%h hi=%h c=%b z=%b e=%b want y=%h e=%b",
                 ops[i], i, bus.out_valid, bus.y, bus.y_hi, bus.carry, bus.zero, bus.err, exp_y[i], exp_err[i]);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_mul();
    bus.in_valid = 1'b1; bus.op = 3'b110; bus.a = 8'hFF; bus.b = 8'hFF;
    tick();
    // New operands presented during the multiply must be ignored.
    bus.op = 3'b000; bus.a = 8'h00; bus.b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if ({bus.in_ready, bus.busy, bus.out_valid} !== 3'b010) begin
        tests_failed++; $display("FAIL mul_busy_cyc%0d got rdy/busy/v=%b want 010", i, {bus.in_ready, bus.busy, bus.out_valid});
      end
      tick();
    end
    bus.in_valid = 1'b0;
    tests_run++;
    if ({bus.out_valid, bus.busy, bus.y_hi, bus.y} !== {1'b1, 1'b0, 16'hFE01}) begin
      tests_failed++; $display("FAIL mul_ff_ff got v=%b busy=%b prod=%h%h want v=1 busy=0 prod=fe01", bus.out_valid, bus.busy, bus.y_hi, bus.y);
    end
    tests_run++;
    if ({bus.carry, bus.zero, bus.err} !== 3'b000) begin
      tests_failed++; $display("FAIL mul_flags got %b want 000", {bus.carry, bus.zero, bus.err});
    end
    tick();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.op = 3'b101; bus.a = 8'hF0; bus.b = 8'h3C;
    tick();
    bus.op = 3'b000; bus.a = 8'h01; bus.b = 8'h02;
    tests_run++;
    if ({bus.in_ready, bus.out_valid, bus.y} !== {1'b0, 1'b1, 8'hCC}) begin
      tests_failed++; $display("FAIL bp_hold1 got rdy=%b v=%b y=%h want rdy=0 v=1 y=cc", bus.in_ready, bus.out_valid, bus.y);
    end
    tick();
    tests_run++;
    if ({bus.in_ready, bus.out_valid, bus.y} !== {1'b0, 1'b1, 8'hCC}) begin
      tests_failed++; $display("FAIL bp_hold2 got rdy=%b v=%b y=%h want rdy=0 v=1 y=cc", bus.in_ready, bus.out_valid, bus.y);
    end
    bus.out_ready = 1'b1;
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_release_rdy got %b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    tests_run++;
    if ({bus.out_valid, bus.y, bus.carry} !== {1'b1, 8'h03, 1'b0}) begin
      tests_failed++; $display("FAIL bp_add got v=%b y=%h c=%b want v=1 y=03 c=0", bus.out_valid, bus.y, bus.carry);
    end
    tick();
    tests_run++;
    if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_drain got %b want 0", bus.out_valid); end
  endtask

  task automatic test_reset_mid_mul();
    bus.in_valid = 1'b1; bus.op = 3'b110; bus.a = 8'h12; bus.b = 8'h34;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.out_valid, bus.busy, bus.in_ready, bus.y_hi, bus.y} !== {1'b0, 1'b0, 1'b1, 16'h0000}) begin
      tests_failed++; $display("FAIL rst_mul got v=%b busy=%b rdy=%b prod=%h%h want v=0 busy=0 rdy=1 prod=0000",
                               bus.out_valid, bus.busy, bus.in_ready, bus.y_hi, bus.y);
    end
    tick();
    rst_n = 1'b1;
    tick();
    tests_run++;
    if ({bus.out_valid, bus.busy} !== 2'b00) begin
      tests_failed++; $display("FAIL rst_mul_after got v/busy=%b want 00", {bus.out_valid, bus.busy});
    end
    bus.in_valid = 1'b1; bus.op = 3'b110; bus.a = 8'h12; bus.b = 8'h34;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    tests_run++;
    if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL mul2_early got %b want 0", bus.out_valid); end
    tick();
    tests_run++;
    if ({bus.out_valid, bus.y_hi, bus.y} !== {1'b1, 16'h03A8}) begin
      tests_failed++; $display("FAIL mul2_prod got v=%b prod=%h%h want v=1 prod=03a8", bus.out_valid, bus.y_hi, bus.y);
    end
    tick();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_add();
    test_back_to_back();
    test_logic_cmp();
    test_mul();
    test_backpressure();
    test_reset_mid_mul();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
